// File: rtl/bcd_scan4_pkg.sv
// Shared constants and helpers for the 4-digit BCD
// counter with multiplexed display scan.
package bcd_scan4_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BLANK_CODE = 4'b1111;

  function automatic logic [NUM_DIGITS-1:0] onehot(
    input logic [1:0] idx
  );
    return NUM_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/bcd_scan4_digit.sv
// One decade counter stage; carry-out is combinational so
// a full-chain ripple settles within a single cycle.
module bcd_digit
  import bcd_scan4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       cin_i,
  output logic [3:0] digit_o,
  output logic       cout_o
);

  logic [3:0] dig_q;
  logic [3:0] dig_d;
  logic       at_max;

  assign at_max  = (dig_q == BCD_MAX);
  assign cout_o  = cin_i & at_max;
  assign digit_o = dig_q;

  always_comb begin
    dig_d = dig_q;
    if (clr_i) begin
      dig_d = 4'd0;
    end else if (cin_i) begin
      dig_d = at_max ? 4'd0 : dig_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= 4'd0;
    end else begin
      dig_q <= dig_d;
    end
  end

endmodule

// File: rtl/bcd_scan4.sv
// 4-digit BCD event counter with sticky wrap flag and a
// time-multiplexed, leading-zero-blanked digit scan.
module bcd_scan4
  import bcd_scan4_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [3:0]            cntl,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  ovf
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

  logic [NUM_DIGITS-1:0][3:0] dig;
  logic [NUM_DIGITS:0]        carry;

  assign carry[0] = inc;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr),
      .cin_i   (carry[g]),
      .digit_o (dig[g]),
      .cout_o  (carry[g+1])
    );
  end

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [1:0]    sel_q;
  logic [1:0]    sel_d;
  logic          ovf_q;
  logic          ovf_d;
  logic          tick;

  assign tick = (presc_q == PS_MAX);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    sel_d   = tick ? sel_q + 2'd1 : sel_q;
    ovf_d   = clr ? 1'b0 : (ovf_q | carry[NUM_DIGITS]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sel_q   <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      ovf_q   <= ovf_d;
    end
  end

  // A digit is blank only when it and every higher digit are zero.
  logic [NUM_DIGITS-1:0] zero;
  logic [NUM_DIGITS-1:0] blank;

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero[k] = (dig[k] == 4'd0);
    end
    blank[3] = zero[3];
    blank[2] = &zero[3:2];
    blank[1] = &zero[3:1];
    blank[0] = 1'b0;
  end

  assign dig_en = onehot(sel_q);
  assign cntl   = blank[sel_q] ? BLANK_CODE : dig[sel_q];
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_bcd_scan4.sv
// Directed checks for bcd_scan4 with a 4-clock scan slot.
module tb_bcd_scan4;

  logic       clk;
  logic       rst_n;
  logic       inc;
  logic       clr;
  logic [3:0] cntl;
  logic [3:0] dig_en;
  logic       ovf;

  int total;
  int bad;

  bcd_scan4 #(.SCAN_DIV(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (inc),
    .clr    (clr),
    .cntl   (cntl),
    .dig_en (dig_en),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_inc(input int n);
    inc = 1'b1;
    repeat (n) step();
    inc = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // Collects the code shown in each slot over one full scan.
  task automatic read_all(output logic [15:0] codes,
                          output logic ok);
    logic [3:0] seen;
    codes = '0;
    seen = '0;
    for (int j = 0; j < 16; j++) begin
      case (dig_en)
        4'b0001: begin codes[3:0]   = cntl; seen[0] = 1'b1; end
        4'b0010: begin codes[7:4]   = cntl; seen[1] = 1'b1; end
        4'b0100: begin codes[11:8]  = cntl; seen[2] = 1'b1; end
        4'b1000: begin codes[15:12] = cntl; seen[3] = 1'b1; end
        default: ;
      endcase
      if (j != 15) step();
    end
    ok = &seen;
  endtask

  task automatic test_reset();
    logic [3:0] exp_en;
    logic [3:0] exp_c;
    rst_n = 1'b0;
    inc = 1'b0;
    clr = 1'b0;
    step();
    total++;
    if (dig_en !== 4'b0001) begin
      bad++;
      $display("FAIL reset_dig_en got=%b want=0001", dig_en);
    end
    total++;
    if (cntl !== 4'b0000) begin
      bad++;
      $display("FAIL reset_cntl got=%b want=0000", cntl);
    end
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b want=0", ovf);
    end
    rst_n = 1'b1;
    for (int j = 0; j < 16; j++) begin
      exp_en = 4'b0001 << ((j / 4) % 4);
      exp_c = (j < 4) ? 4'b0000 : 4'b1111;
      total++;
      if (dig_en !== exp_en || cntl !== exp_c) begin
        bad++;
        $display("FAIL idle_scan[%0d] got=%b/%b want=%b/%b",
                 j, dig_en, cntl, exp_en, exp_c);
      end
      step();
    end
  endtask

  task automatic test_carry();
    logic [15:0] c;
    logic ok;
    run_inc(199);
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'hF199) begin
      bad++;
      $display("FAIL cnt_0199 got=%h ok=%b want=f199", c, ok);
    end
    run_inc(1);
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'hF200) begin
      bad++;
      $display("FAIL cnt_0200 got=%h ok=%b want=f200", c, ok);
    end
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_0200 got=%b want=0", ovf);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] c;
    logic ok;
    do_clr();
    run_inc(9999);
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'h9999 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL cnt_9999 got=%h ovf=%b want=9999/0", c, ovf);
    end
    run_inc(1);
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'hFFF0 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL wrap got=%h ovf=%b want=fff0/1", c, ovf);
    end
    run_inc(5);
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'hFFF5 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL post_wrap got=%h ovf=%b want=fff5/1", c, ovf);
    end
  endtask

  task automatic test_clr_inc();
    logic [15:0] c;
    logic ok;
    run_inc(37);
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'hFF42 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL cnt_0042 got=%h ovf=%b want=ff42/1", c, ovf);
    end
    inc = 1'b1;
    clr = 1'b1;
    step();
    inc = 1'b0;
    clr = 1'b0;
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'hFFF0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL clr_inc got=%h ovf=%b want=fff0/0", c, ovf);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] c;
    logic ok;
    logic found;
    do_clr();
    run_inc(1234);
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'h1234) begin
      bad++;
      $display("FAIL cnt_1234 got=%h ok=%b want=1234", c, ok);
    end
    found = 1'b0;
    for (int j = 0; j < 16 && !found; j++) begin
      if (dig_en === 4'b0100) found = 1'b1;
      else step();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL slot2_wait got=timeout want=0100");
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dig_en !== 4'b0001 || cntl !== 4'b0000 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got=%b/%b/%b want=0001/0000/0",
               dig_en, cntl, ovf);
    end
    step();
    rst_n = 1'b1;
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'hFFF0) begin
      bad++;
      $display("FAIL after_rst got=%h ok=%b want=fff0", c, ok);
    end
  endtask

  task automatic test_continuous();
    logic [15:0] c;
    logic ok;
    inc = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      total++;
      if (cntl > 4'd9 && cntl !== 4'b1111) begin
        bad++;
        $display("FAIL cont_code[%0d] got=%b want=0..9/1111", j, cntl);
      end
    end
    inc = 1'b0;
    read_all(c, ok);
    total++;
    if (!ok || c !== 16'hFF12) begin
      bad++;
      $display("FAIL cnt_0012 got=%h ok=%b want=ff12", c, ok);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_carry();
    test_wrap();
    test_clr_inc();
    test_async_reset();
    test_continuous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan4.md
BCD_SCAN4 -- requirements
Module: bcd_scan4

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clocks per digit scan slot, legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port inc, input, 1 bit: count event, one increment per clock it is high.
REQ-005 SHALL have port clr, input, 1 bit: synchronous clear of count and overflow.
REQ-006 SHALL have port cntl, output, 4 bits: BCD code of the selected digit, driving the 7-segment decoder cntl input.
REQ-007 SHALL have port dig_en, output, 4 bits: one-hot, active-high digit enable; bit k selects digit k, 0 = least significant.
REQ-008 SHALL have port ovf, output, 1 bit: sticky wrap flag.

Function
REQ-009 SHALL hold a 4-digit BCD count d3..d0; each digit is 0..9 only.
REQ-010 SHALL, when clr=1 at a clock edge, set all digits to 0 and ovf to 0; clr overrides inc.
REQ-011 SHALL, when inc=1 and clr=0, add 1 to the count at that edge; carries ripple through all digits in the same cycle (0199 -> 0200).
REQ-012 SHALL wrap 9999 + inc to 0000 and set ovf=1 on that edge; ovf then holds until clr or reset.
REQ-013 SHALL leave the count unchanged when inc=0 and clr=0.
REQ-014 SHALL run a prescaler that counts 0..SCAN_DIV-1 and wraps; its terminal count is the scan tick.
REQ-015 SHALL advance a 2-bit scan index 0->1->2->3->0 on each scan tick; the index is otherwise held.
REQ-016 SHALL drive dig_en as the one-hot decode of the scan index and cntl as the selected digit, both combinational from registered state so they change on the same edge.
REQ-017 SHALL blank leading zeros: for k=1..3, digit k is blanked when it and all higher digits are 0; digit 0 is never blanked.
REQ-018 SHALL drive cntl=4'b1111 for a blanked digit; the downstream decoder outputs all segments off for codes 10..15.
REQ-019 SHALL leave the count unaffected by scanning; a count change on the cycle of a scan tick is visible in cntl from the next edge.
REQ-020 SHALL leave the prescaler and scan index unaffected by clr.

Reset
REQ-021 SHALL, while rst_n=0, immediately force digits=0, ovf=0, prescaler=0 and scan index=0, giving dig_en=0001 and cntl=0000.
REQ-022 SHALL, after reset is asserted mid-count or mid-scan, resume only from the reset values; no partial state is retained.
REQ-023 SHALL use asynchronous assertion of rst_n in every register; no register is left without reset.

Structure
REQ-024 SHALL place BLANK_CODE (4'b1111), NUM_DIGITS (4) and the BCD maximum (9) in the shared display package.
REQ-025 SHALL implement one sub-module, bcd_digit: one decade counter with carry-in, carry-out, synchronous clear and async reset, instantiated four times in a carry chain.
REQ-026 SHALL compute the prescaler width from SCAN_DIV.

Verification (SCAN_DIV=4)
REQ-027 SHALL cover reset then idle 16 clocks: dig_en cycles 0001,0010,0100,1000 at 4 clocks each; cntl=0000 on digit 0 and 1111 on the others.
REQ-028 SHALL cover 199 inc pulses, then 1 more: count 0199 -> 0200; in the digit-2 slot cntl=0010, digit-1 slot cntl=0000 (not blanked), digit-3 slot cntl=1111.
REQ-029 SHALL cover 9999 incs then 1 more: count 0000, ovf=1; 5 more incs give digit-0 cntl=0101 with ovf still 1.
REQ-030 SHALL cover inc=1 and clr=1 on the same edge at count 0042: result 0000, ovf=0.
REQ-031 SHALL cover rst_n pulsed low asynchronously between edges at count 1234 with scan index 2: outputs go to dig_en=0001, cntl=0000 before the next edge.
REQ-032 SHALL cover continuous inc=1 for 12 clocks across scan ticks: count=0012, and no digit code outside 0..9 or 1111 ever appears.
